// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the I/D memory arbiter.
// Holds the FSM state encoding, owner constants and the byte-lane merge used
// by partial-store read-modify-write.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // no access in flight
      ST_RD   = 2'd1,   // read issued last cycle, response due now
      ST_RMW  = 2'd2    // write-back half of a partial store
   } state_e;

   // Owner / last-grant encoding
   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   // Replace the strobed byte lanes of old_w with those of new_w
   function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch (I) and data (D) requests.
// Default build: fixed priority, D beats I.
// With MEM_ARB_RR_EN defined: on a conflict the side not granted last wins.
// No grant is given while busy (RMW write-back or reset).
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic i_req_i,
   input  logic d_req_i,
   input  logic last_grant_i,
   input  logic busy_i,
   output logic gnt_i_o,
   output logic gnt_d_o
);

   logic d_wins;

`ifdef MEM_ARB_RR_EN
   // D wins if alone, or on conflict when I took the previous grant
   assign d_wins = d_req_i && (!i_req_i || (last_grant_i == OWN_I));
`else
   assign d_wins = d_req_i;

   // History is irrelevant under fixed priority
   logic unused_last_grant;
   assign unused_last_grant = last_grant_i;
`endif

   assign gnt_d_o = !busy_i && d_wins;
   assign gnt_i_o = !busy_i && i_req_i && !d_wins;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between instruction fetch
// and data load/store. One RAM access per cycle, read data one cycle later.
// Sub-word stores become a read followed by a merged whole-word write.
// Optional MEM_ARB_RR_EN selects alternating priority on conflicts.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_gnt,
   output logic                i_rvalid,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [DATA_W/8-1:0] d_wstrb,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                m_we,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_din,
   input  logic [DATA_W-1:0]   m_dout
);

   state_e              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_grant_q, last_grant_d;
   logic [ADDR_W-3:0]   rmw_word_q;
   logic [DATA_W-1:0]   rmw_wdata_q;
   logic [DATA_W/8-1:0] rmw_strb_q;
   logic [ADDR_W-1:0]   m_addr_q;
   logic [DATA_W-1:0]   m_din_q;

   logic busy, gnt_i, gnt_d;
   logic d_full, d_null, d_part;

   // RAM is word addressed; byte offsets never reach it
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

   // Store classification by strobe pattern
   assign d_null = d_we && (d_wstrb == '0);
   assign d_full = d_we && (d_wstrb == '1);
   assign d_part = d_we && !d_null && !d_full;

   // Write-back cycle owns the RAM; reset gates every grant low
   assign busy = (state_q == ST_RMW) || !rst_n;

   mem_arb_pick u_pick (
      .i_req_i      (i_req),
      .d_req_i      (d_req),
      .last_grant_i (last_grant_q),
      .busy_i       (busy),
      .gnt_i_o      (gnt_i),
      .gnt_d_o      (gnt_d)
   );

   // State register with read owner and arbitration history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         owner_q      <= OWN_I;
         last_grant_q <= OWN_I;
      end else begin
         // NOTE: flops use non-blocking assignment so every register samples
         // pre-edge values regardless of block evaluation order.
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Next-state logic: a granted read or partial store starts a new access
   always_comb begin
      // NOTE: defaults first so every path assigns every output; otherwise a
      // latch is inferred.
      state_d      = ST_IDLE;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      unique case (state_q)
         ST_RMW: state_d = ST_IDLE;
         default: begin
            if (gnt_i) begin
               state_d      = ST_RD;
               owner_d      = OWN_I;
               last_grant_d = OWN_I;
            end else if (gnt_d) begin
               last_grant_d = OWN_D;
               if (!d_we) begin
                  state_d = ST_RD;
                  owner_d = OWN_D;
               end else if (d_part) begin
                  state_d = ST_RMW;
               end
            end
         end
      endcase
   end

   // Output logic: handshakes, read return steering and RAM command mux
   always_comb begin
      i_gnt    = gnt_i;
      d_gnt    = gnt_d;
      i_rvalid = (state_q == ST_RD) && (owner_q == OWN_I);
      d_rvalid = (state_q == ST_RD) && (owner_q == OWN_D);
      i_rdata  = i_rvalid ? m_dout : '0;
      d_rdata  = d_rvalid ? m_dout : '0;
      m_we     = 1'b0;
      m_addr   = m_addr_q;
      m_din    = m_din_q;
      if (state_q == ST_RMW) begin
         m_we   = rst_n;
         m_addr = {rmw_word_q, 2'b00};
         m_din  = byte_merge(m_dout, rmw_wdata_q, rmw_strb_q);
      end else if (gnt_i) begin
         m_addr = {i_addr[ADDR_W-1:2], 2'b00};
      end else if (gnt_d && !d_null) begin
         m_addr = {d_addr[ADDR_W-1:2], 2'b00};
         if (d_full) begin
            m_we  = 1'b1;
            m_din = d_wdata;
         end
      end
   end

   // Held RAM bus values and the partial-store context for write-back
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: these registers are reset too (few bits) so the RAM bus
         // reads all-zero during and right after reset.
         m_addr_q    <= '0;
         m_din_q     <= '0;
         rmw_word_q  <= '0;
         rmw_wdata_q <= '0;
         rmw_strb_q  <= '0;
      end else begin
         m_addr_q <= m_addr;
         m_din_q  <= m_din;
         if (gnt_d && d_part) begin
            rmw_word_q  <= d_addr[ADDR_W-1:2];
            rmw_wdata_q <= d_wdata;
            rmw_strb_q  <= d_wstrb;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: RAM model, transaction-level reference
// model checked on every negedge, directed scenarios with literal values,
// then randomized traffic. Build with MEM_ARB_RR_EN for the round-robin variant.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req, i_gnt, i_rvalid;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [3:0]  d_wstrb;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        m_we;
   logic [31:0] m_addr, m_din, m_dout;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_req    (i_req),
      .i_addr   (i_addr),
      .i_gnt    (i_gnt),
      .i_rvalid (i_rvalid),
      .i_rdata  (i_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_wstrb  (d_wstrb),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_gnt    (d_gnt),
      .d_rvalid (d_rvalid),
      .d_rdata  (d_rdata),
      .m_we     (m_we),
      .m_addr   (m_addr),
      .m_din    (m_din),
      .m_dout   (m_dout)
   );

   // 4KB RAM: registered read, whole-word write
   logic [31:0] ram     [0:1023];
   logic [31:0] ref_mem [0:1023];

   initial begin
      for (int k = 0; k < 1024; k++) begin
         ram[k]     = 32'hC0DE_0000 | k;
         ref_mem[k] = 32'hC0DE_0000 | k;
      end
      ram[3]     = 32'h1122_3344;
      ref_mem[3] = 32'h1122_3344;
      forever begin
         @(posedge clk);
         m_dout <= ram[m_addr[11:2]];
         if (m_we) ram[m_addr[11:2]] = m_din;
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic logic [31:0] tb_merge(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] s);
      logic [31:0] mask = 32'd0;
      for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
      return (o & ~mask) | (n & mask);
   endfunction

   // Reference model state: pending read response, pending write-back, held bus
   logic        pv = 1'b0, po = 1'b0;
   logic [31:0] pd = 32'd0;
   logic        rp = 1'b0;
   logic [9:0]  r_idx = 10'd0;
   logic [31:0] r_wdata = 32'd0;
   logic [3:0]  r_strb = 4'd0;
   logic [31:0] la = 32'd0, ld = 32'd0;
`ifdef MEM_ARB_RR_EN
   logic        lg = 1'b0;   // 0 = I granted last, 1 = D
`endif

   always @(negedge clk) begin
      logic        eg_i, eg_d, e_we, iv, dv;
      logic [31:0] e_addr, e_din;
      if (!rst_n) begin
         check("rst_ctl", {i_gnt, d_gnt, i_rvalid, d_rvalid, m_we}, 64'd0);
         check("rst_rdata", {i_rdata, d_rdata}, 64'd0);
         check("rst_bus", {m_addr, m_din}, 64'd0);
         pv = 1'b0; rp = 1'b0; la = 32'd0; ld = 32'd0;
`ifdef MEM_ARB_RR_EN
         lg = 1'b0;
`endif
      end else begin
         eg_i = 1'b0;
         eg_d = 1'b0;
         if (!rp) begin
`ifdef MEM_ARB_RR_EN
            if (i_req && d_req) begin
               eg_d = !lg;
               eg_i = lg;
            end else begin
               eg_d = d_req;
               eg_i = i_req;
            end
`else
            eg_d = d_req;
            eg_i = i_req && !d_req;
`endif
         end
         iv = pv && !po;
         dv = pv && po;
         check("gnt", {i_gnt, d_gnt}, {eg_i, eg_d});
         check("i_resp", {i_rvalid, i_rdata}, {iv, iv ? pd : 32'd0});
         check("d_resp", {d_rvalid, d_rdata}, {dv, dv ? pd : 32'd0});
         e_we = 1'b0; e_addr = la; e_din = ld;
         if (rp) begin
            e_we   = 1'b1;
            e_addr = {20'd0, r_idx, 2'b00};
            e_din  = tb_merge(ref_mem[r_idx], r_wdata, r_strb);
            ref_mem[r_idx] = e_din;
         end else if (eg_i) begin
            e_addr = i_addr & ~32'h3;
         end else if (eg_d && !(d_we && d_wstrb == 4'h0)) begin
            e_addr = d_addr & ~32'h3;
            if (d_we && d_wstrb == 4'hF) begin
               e_we  = 1'b1;
               e_din = d_wdata;
               ref_mem[d_addr[11:2]] = d_wdata;
            end
         end
         check("m_we", m_we, e_we);
         check("m_addr", m_addr, e_addr);
         check("m_din", m_din, e_din);
         pv = eg_i || (eg_d && !d_we);
         po = eg_d;
         pd = eg_i ? ref_mem[i_addr[11:2]] : ref_mem[d_addr[11:2]];
         rp = eg_d && d_we && d_wstrb != 4'h0 && d_wstrb != 4'hF;
         r_idx = d_addr[11:2]; r_wdata = d_wdata; r_strb = d_wstrb;
`ifdef MEM_ARB_RR_EN
         if (eg_i) lg = 1'b0;
         else if (eg_d) lg = 1'b1;
`endif
         la = e_addr; ld = e_din;
      end
   end

   // Fetch one word; waits a bounded number of cycles for the grant
   task automatic fetch(input logic [31:0] a, output logic [31:0] d);
      logic got = 1'b0;
      i_req = 1'b1; i_addr = a;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk); got = i_gnt;
         @(posedge clk); #1;
      end
      i_req = 1'b0;
      check("fetch_granted", got, 1);
      @(negedge clk); d = i_rdata;
      @(posedge clk); #1;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1);
   end

   initial begin : main
      logic [2:0]  gi, gd, ri, rd, gp, rv;
      logic [31:0] rdw, t2_data;
      logic        ig, dg;
      int          sel;
      rst_n = 1'b1;
      i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_wstrb = 0; d_addr = 0; d_wdata = 0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: lone fetch of 0x004
      i_req = 1'b1; i_addr = 32'h4;
      @(negedge clk);
      check("t1_i_gnt", i_gnt, 1);
      check("t1_m_addr", m_addr, 32'h4);
      @(posedge clk); #1; i_req = 1'b0;
      @(negedge clk);
      check("t1_i_rvalid", i_rvalid, 1);
      check("t1_i_rdata", i_rdata, 32'hC0DE_0001);
      @(posedge clk); #1;

      // 2: fetch and load 0x008 competing for three cycles
      i_req = 1'b1; i_addr = 32'h4; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
      t2_data = 32'd0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k < 3) begin gi[k] = i_gnt; gd[k] = d_gnt; end
         if (k > 0) begin ri[k-1] = i_rvalid; rd[k-1] = d_rvalid; end
         if (k == 1) t2_data = d_rdata;
         @(posedge clk); #1;
         if (k == 2) begin i_req = 1'b0; d_req = 1'b0; end
      end
`ifdef MEM_ARB_RR_EN
      check("t2_i_gnts", gi, 3'b010);
      check("t2_d_gnts", gd, 3'b101);
      check("t2_i_rvalids", ri, 3'b010);
      check("t2_d_rvalids", rd, 3'b101);
`else
      check("t2_i_gnts", gi, 3'b000);
      check("t2_d_gnts", gd, 3'b111);
      check("t2_i_rvalids", ri, 3'b000);
      check("t2_d_rvalids", rd, 3'b111);
`endif
      check("t2_d_rdata", t2_data, 32'hC0DE_0002);

      // 3: partial store into 0x00C (old 0x11223344), fetch waiting during RMW
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'hC; d_wstrb = 4'h2; d_wdata = 32'h0000_AB00;
      @(negedge clk);
      check("t3_d_gnt", d_gnt, 1);
      check("t3_read_issue_we", m_we, 0);
      @(posedge clk); #1;
      d_req = 1'b0; d_we = 1'b0; i_req = 1'b1; i_addr = 32'h0;
      @(negedge clk);
      check("t3_rmw_no_gnt", {i_gnt, d_gnt}, 2'b00);
      check("t3_rmw_we", m_we, 1);
      check("t3_rmw_addr", m_addr, 32'hC);
      check("t3_rmw_din", m_din, 32'h1122_AB44);
      @(posedge clk); #1;
      @(negedge clk);
      check("t3_i_gnt_after", i_gnt, 1);
      @(posedge clk); #1; i_req = 1'b0;
      fetch(32'hC, rdw);
      check("t3_readback", rdw, 32'h1122_AB44);

      // 4: back-to-back fetches 0x0, 0x4, 0x8
      i_req = 1'b1; i_addr = 32'h0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k < 3) gp[k] = i_gnt;
         if (k > 0) begin
            rv[k-1] = i_rvalid;
            check("t4_rdata", i_rdata, 32'hC0DE_0000 | (k - 1));
         end
         @(posedge clk); #1;
         if (k < 2) i_addr = 32'(4 * (k + 1));
         else i_req = 1'b0;
      end
      check("t4_gnts", gp, 3'b111);
      check("t4_rvalids", rv, 3'b111);

      // 5: reset asserted during the write-back cycle of a partial store
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h14; d_wstrb = 4'h1; d_wdata = 32'hFF;
      @(negedge clk);
      check("t5_d_gnt", d_gnt, 1);
      @(posedge clk); #1;
      d_req = 1'b0; d_we = 1'b0; rst_n = 1'b0; i_req = 1'b1; i_addr = 32'h0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("t5_rst_we_gnt", {m_we, i_gnt, d_gnt}, 3'b000);
         @(posedge clk); #1;
      end
      rst_n = 1'b1; i_req = 1'b0;
      fetch(32'h14, rdw);
      check("t5_word_kept", rdw, 32'hC0DE_0005);

      // 6: store with empty strobe
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h18; d_wstrb = 4'h0; d_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      check("t6_d_gnt", d_gnt, 1);
      check("t6_we_grant", m_we, 0);
      @(posedge clk); #1; d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      check("t6_we_after", m_we, 0);
      @(posedge clk); #1;
      fetch(32'h18, rdw);
      check("t6_word_kept", rdw, 32'hC0DE_0006);

      // Randomized traffic in a small address window to force reuse
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk); ig = i_gnt; dg = d_gnt;
         @(posedge clk); #1;
         if (c == 1000) rst_n = 1'b0;
         if (c == 1003) rst_n = 1'b1;
         if (!i_req || ig) begin
            i_req = ($urandom_range(0, 3) != 0);
            i_addr = $urandom_range(0, 63);
         end
         if (!d_req || dg) begin
            d_req   = ($urandom_range(0, 3) != 0);
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = $urandom_range(0, 63);
            d_wdata = $urandom;
            sel     = int'($urandom_range(0, 3));
            if (sel == 0) d_wstrb = 4'h0;
            else if (sel == 1) d_wstrb = 4'hF;
            else d_wstrb = 4'($urandom_range(1, 14));
         end
      end
      i_req = 1'b0; d_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
